// File: rtl/mtx_mvmul_unit_pkg.sv
// mtx_types: shared matrix/vector types plus the MVMUL execution-unit
// additions (accumulator type, ternary multiply, q31 saturation, FSM states).
// No ports; imported by the MVMUL interface, row datapath and top.
package mtx_types;

    localparam int unsigned R     = 16;
    localparam int unsigned C     = 16;
    localparam int unsigned V     = 16;
    localparam int unsigned ACC_W = 37;

    // 2'b11 is not a member: it decodes as zero and is reported as invalid.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        PLUS  = 2'b01,
        MINUS = 2'b10
    } val3_t;

    typedef logic signed [31:0] q31_t;

    typedef struct packed {
        val3_t [R-1:0][C-1:0] data3;
    } mtx_t;

    typedef struct packed {
        q31_t [V-1:0] vec;
    } vec_t;

    typedef union packed {
        mtx_t mtx;
        vec_t vec;
    } mv_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic zero;
        logic inv;
    } status_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        q31_t val;
        logic of;
        logic uf;
    } sat_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mvmul_state_t;

    localparam acc_t Q31_MAX = acc_t'({{(ACC_W-31){1'b0}}, {31{1'b1}}});
    localparam acc_t Q31_MIN = acc_t'({{(ACC_W-31){1'b1}}, {31{1'b0}}});

    // Negation happens after widening, so MINUS x 0x80000000 yields +2^31.
    function automatic acc_t mul3_ext(val3_t code, q31_t x);
        acc_t xe;
        xe = {{(ACC_W-32){x[31]}}, x};
        case (code)
            PLUS:    return xe;
            MINUS:   return -xe;
            default: return '0;
        endcase
    endfunction

    function automatic sat_t sat_acc(acc_t a);
        sat_t s;
        s.val = a[31:0];
        s.of  = 1'b0;
        s.uf  = 1'b0;
        if (a > Q31_MAX) begin
            s.val = 32'h7FFF_FFFF;
            s.of  = 1'b1;
        end else if (a < Q31_MIN) begin
            s.val = 32'h8000_0000;
            s.uf  = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/mtx_mvmul_unit_if.sv
// MVMUL request/response bundle.
//   start        request pulse
//   m_in / v_in  matrix and vector operands
//   busy / done  unit occupied / result valid pulse
//   v_out / st   result vector and status flags
// master = issuing stage, slave = mtx_mvmul_unit.
interface mtx_mvmul_unit_if;
    import mtx_types::*;

    logic    start;
    mv_t     m_in;
    mv_t     v_in;
    logic    busy;
    logic    done;
    mv_t     v_out;
    status_t st;

    modport master (output start, m_in, v_in, input busy, done, v_out, st);
    modport slave  (input start, m_in, v_in, output busy, done, v_out, st);

endinterface

// File: rtl/mtx_mvmul_unit_row_dot.sv
// mtx_row_dot: one ternary-matrix row times a q31 vector, saturated to q31.
//   clk, rst  only present when MVMUL_PIPE_EN is defined
//   row       COLS ternary codes of the selected matrix row
//   vec       COLS q31 lanes
//   res       saturated dot product
//   of, uf    saturation indications
//   inv       a 2'b11 code appeared in the row
// MVMUL_PIPE_EN: registers the term products ahead of the adder tree.
module mtx_row_dot
    import mtx_types::*;
#(
    parameter int unsigned COLS  = C,
    parameter int unsigned ACC_W = mtx_types::ACC_W
) (
`ifdef MVMUL_PIPE_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  val3_t [COLS-1:0]   row,
    input  q31_t  [COLS-1:0]   vec,
    output q31_t               res,
    output logic               of,
    output logic               uf,
    output logic               inv
);

    typedef logic signed [ACC_W-1:0] sum_t;

    sum_t terms [COLS];
    logic bad;
    sum_t sum_terms [COLS];
    logic sum_bad;
    sat_t sat;

    always_comb begin
        bad = 1'b0;
        for (int unsigned i = 0; i < COLS; i++) begin
            terms[i] = sum_t'(mul3_ext(row[i], vec[i]));
            if (2'(row[i]) == 2'b11) bad = 1'b1;
        end
    end

`ifdef MVMUL_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < COLS; i++) sum_terms[i] <= '0;
            sum_bad <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < COLS; i++) sum_terms[i] <= terms[i];
            sum_bad <= bad;
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < COLS; i++) sum_terms[i] = terms[i];
        sum_bad = bad;
    end
`endif

    // Heap-ordered tree: leaves at COLS-1..2*COLS-2, node p sums 2p+1 and 2p+2.
    function automatic sum_t tree_sum(input sum_t t [COLS]);
        sum_t node [2*COLS-1];
        for (int unsigned i = 0; i < COLS; i++) node[COLS-1+i] = t[i];
        for (int unsigned i = COLS-1; i > 0; i--) node[i-1] = node[2*i-1] + node[2*i];
        return node[0];
    endfunction

    always_comb begin
        sat = sat_acc(acc_t'(tree_sum(sum_terms)));
        res = sat.val;
        of  = sat.of;
        uf  = sat.uf;
        inv = sum_bad;
    end

endmodule

// File: rtl/mtx_mvmul_unit.sv
// mtx_mvmul_unit: MVMUL execution unit, V0 = M0 x V0.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave side of mtx_mvmul_unit_if (start, m_in, v_in -> busy, done, v_out, st)
// Operands are latched on an accepted start; one row is produced per RUN
// cycle; done pulses for one cycle with v_out/st, which then hold.
// MVMUL_PIPE_EN: one extra RUN cycle for the registered term products.
module mtx_mvmul_unit
    import mtx_types::*;
#(
    parameter int unsigned ROWS  = R,
    parameter int unsigned COLS  = C,
    parameter int unsigned ACC_W = mtx_types::ACC_W
) (
    input logic              clk,
    input logic              rst,
    mtx_mvmul_unit_if.slave  bus
);

`ifdef MVMUL_PIPE_EN
    localparam int unsigned PIPE = 1;
`else
    localparam int unsigned PIPE = 0;
`endif
    localparam int unsigned RUN_LEN = ROWS + PIPE;
    localparam int unsigned CNT_W   = $clog2(RUN_LEN);
    localparam int unsigned ROW_W   = $clog2(ROWS);

    mvmul_state_t     state;
    logic [CNT_W-1:0] cnt;
    mv_t              m_reg, v_reg, res_reg, res_next;
    logic             of_acc, uf_acc, inv_acc;
    logic             of_n, uf_n, inv_n;
    logic [ROW_W-1:0] sel, wr_idx;
    logic             wr_en;
    q31_t             row_res;
    logic             row_of, row_uf, row_inv;

    mtx_row_dot #(.COLS(COLS), .ACC_W(ACC_W)) u_row_dot (
`ifdef MVMUL_PIPE_EN
        .clk (clk),
        .rst (rst),
`endif
        .row (m_reg.mtx.data3[sel]),
        .vec (v_reg.vec.vec),
        .res (row_res),
        .of  (row_of),
        .uf  (row_uf),
        .inv (row_inv)
    );

    // With the product register, the lane written trails the selected row by one.
    always_comb begin
        sel = ROW_W'(cnt);
`ifdef MVMUL_PIPE_EN
        wr_en  = (state == RUN) && (cnt != '0);
        wr_idx = ROW_W'(cnt - 1'b1);
`else
        wr_en  = (state == RUN);
        wr_idx = ROW_W'(cnt);
`endif
        res_next = res_reg;
        if (wr_en) res_next.vec.vec[wr_idx] = row_res;
        of_n  = of_acc | (wr_en & row_of);
        uf_n  = uf_acc | (wr_en & row_uf);
        inv_n = inv_acc | (wr_en & row_inv) | bus.start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            m_reg     <= '0;
            v_reg     <= '0;
            res_reg   <= '0;
            of_acc    <= 1'b0;
            uf_acc    <= 1'b0;
            inv_acc   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.v_out <= '0;
            bus.st    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        m_reg    <= bus.m_in;
                        v_reg    <= bus.v_in;
                        of_acc   <= 1'b0;
                        uf_acc   <= 1'b0;
                        inv_acc  <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_reg <= res_next;
                    of_acc  <= of_n;
                    uf_acc  <= uf_n;
                    inv_acc <= inv_n;
                    if (cnt == CNT_W'(RUN_LEN - 1)) begin
                        // Publish including the row written on this same edge.
                        bus.v_out <= res_next;
                        bus.st    <= '{of: of_n, uf: uf_n, zero: (res_next == '0), inv: inv_n};
                        bus.done  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) inv_acc <= 1'b1;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtx_mvmul_unit.sv
// Directed bench for mtx_mvmul_unit; expected values are hand-derived
// constants. Define MVMUL_PIPE_EN to check the pipelined latency.
module tb_mtx_mvmul_unit;
    import mtx_types::*;

`ifdef MVMUL_PIPE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mtx_mvmul_unit_if bus ();

    mtx_mvmul_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_val);
        checks++;
        if (obs !== exp_val) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_val);
        end
    endtask

    function automatic mv_t fill_m(val3_t code);
        mv_t m;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) m.mtx.data3[r][c] = code;
        return m;
    endfunction

    function automatic mv_t fill_v(q31_t x);
        mv_t v;
        for (int i = 0; i < V; i++) v.vec.vec[i] = x;
        return v;
    endfunction

    function automatic mv_t ident();
        mv_t m;
        m = fill_m(ZERO);
        for (int i = 0; i < R; i++) m.mtx.data3[i][i] = PLUS;
        return m;
    endfunction

    function automatic mv_t ramp();
        mv_t v;
        for (int i = 0; i < V; i++) v.vec.vec[i] = q31_t'(i) <<< 24;
        return v;
    endfunction

    // mode 0: plain; mode 1: inputs changed in cycle 2, start re-pulsed in
    // cycle 5; mode 2: reset pulse inside cycle 9 (no done expected).
    task automatic run_op(input string tag, input mv_t m, input mv_t v,
                          input mv_t exp_v, input status_t exp_st, input int mode);
        int ndone = 0;
        int dcyc  = 0;
        bus.m_in  = m;
        bus.v_in  = v;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= LAT + 2; cyc++) begin
            if (cyc == 1) check({tag, "_busy_c1"}, 512'(bus.busy), 512'(1));
            if (cyc == LAT + 1) check({tag, "_busy_idle"}, 512'(bus.busy), 512'(0));
            if (bus.done) begin
                ndone++;
                dcyc = cyc;
                check({tag, "_busy_done"}, 512'(bus.busy), 512'(1));
                check({tag, "_vout"}, bus.v_out, exp_v);
                check({tag, "_st"}, 512'(bus.st), 512'(exp_st));
            end
            if (mode == 1 && cyc == 2) begin
                bus.m_in = fill_m(MINUS);
                bus.v_in = fill_v(32'h1234_5678);
            end
            if (mode == 1 && cyc == 5) bus.start = 1'b1;
            if (mode == 1 && cyc == 6) bus.start = 1'b0;
            if (mode == 2 && cyc == 9) begin
                #2 rst = 1'b1;
                #1;
                check({tag, "_rst_busy"}, 512'(bus.busy), 512'(0));
                check({tag, "_rst_done"}, 512'(bus.done), 512'(0));
                check({tag, "_rst_vout"}, bus.v_out, 512'(0));
                check({tag, "_rst_st"}, 512'(bus.st), 512'(0));
                #1 rst = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (mode == 2) begin
            check({tag, "_ndone"}, 512'(ndone), 512'(0));
            check({tag, "_vout_cleared"}, bus.v_out, 512'(0));
        end else begin
            check({tag, "_ndone"}, 512'(ndone), 512'(1));
            check({tag, "_done_cyc"}, 512'(dcyc), 512'(LAT));
            check({tag, "_vout_held"}, bus.v_out, exp_v);
        end
    endtask

    initial begin
        mv_t m, v, e;
        bus.start = 1'b0;
        bus.m_in  = '0;
        bus.v_in  = '0;
        #12;
        check("reset_busy", 512'(bus.busy), 512'(0));
        check("reset_done", 512'(bus.done), 512'(0));
        check("reset_vout", bus.v_out, 512'(0));
        check("reset_st", 512'(bus.st), 512'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_op("ident", ident(), ramp(), ramp(), 4'b0000, 0);

        run_op("minus_exact", fill_m(MINUS), fill_v(32'h0800_0000),
               fill_v(32'h8000_0000), 4'b0000, 0);

        run_op("plus_of", fill_m(PLUS), fill_v(32'h7FFF_FFFF),
               fill_v(32'h7FFF_FFFF), 4'b1000, 0);

        run_op("minus_uf", fill_m(MINUS), fill_v(32'h7FFF_FFFF),
               fill_v(32'h8000_0000), 4'b0100, 0);

        m = fill_m(ZERO);
        m.mtx.data3[0][0] = MINUS;
        v = fill_v(32'h0);
        v.vec.vec[0] = 32'h8000_0000;
        e = fill_v(32'h0);
        e.vec.vec[0] = 32'h7FFF_FFFF;
        run_op("neg_min", m, v, e, 4'b1000, 0);

        run_op("zero_m", fill_m(ZERO), ramp(), fill_v(32'h0), 4'b0010, 0);

        run_op("restart", ident(), ramp(), ramp(), 4'b0001, 1);

        m = ident();
        m.mtx.data3[0][1] = val3_t'(2'b11);
        run_op("code11", m, ramp(), ramp(), 4'b0001, 0);

        run_op("abort", fill_m(PLUS), fill_v(32'h7FFF_FFFF), '0, 4'b0000, 2);

        run_op("after_rst", ident(), ramp(), ramp(), 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/mtx_mvmul_unit.md
Name: mtx_mvmul_unit

Overview:
- Execution unit for the MVMUL instruction: V0 = M0 x V0.
- M0 is a 16x16 ternary matrix of val3_t; V0 is 16 q31_t lanes.
- Sits downstream of the VLIW decode stage and the register file.
- Captures operands on start, produces one output row per cycle, saturates each row to q31, then returns the result vector plus a status_t.

Parameters:
- ROWS, 16 (mtx_types::R), number of rows iterated.
- COLS, 16 (mtx_types::C), terms per dot product. Must equal V.
- ACC_W, 37, signed accumulator width. Requires ACC_W >= 32 + clog2(COLS) + 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse. Accepted only in IDLE.
- m_in  in  512 (mv_t)  matrix operand, read as .mtx.data3[r][c].
- v_in  in  512 (mv_t)  vector operand, read as .vec.vec[i].
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when v_out and st are valid.
- v_out  out  512 (mv_t)  result vector. Held until the next accepted start completes.
- st  out  4 (status_t)  {of, uf, zero, inv}. Held like v_out.

Behaviour:
- Reset is asynchronous, active-high. Outputs during and after reset:
  - busy=0, done=0, v_out=0, st=0.
  - State IDLE, row counter 0.
  - Internal operand and result registers cleared.
- States: IDLE, RUN, DONE.
  - IDLE and start=1: latch m_in and v_in into internal registers. Clear the of/uf/inv accumulators. Go to RUN with row=0. Inputs may change freely afterwards.
  - RUN: each cycle compute the dot product of row r and write it to result lane r.
    - row == ROWS-1: go to DONE.
    - Otherwise: row += 1.
  - DONE: done=1 for exactly this cycle. v_out and st update at the start of DONE, visible in the same cycle as done. Return to IDLE.
- Latency, with start sampled at edge 0:
  - RUN occupies cycles 1..16.
  - done=1 in cycle 17.
  - A new start is accepted in cycle 18.
  - Back-to-back throughput is 18 cycles per operation.
- Per-term arithmetic:
  - Sign-extend the lane to ACC_W before the multiply.
  - PLUS gives +x. ZERO gives 0. MINUS gives -x, computed in ACC_W so that MINUS x 0x80000000 = +2^31 with no 32-bit wrap.
  - Code 2'b11 is treated as ZERO and sets inv.
- Row result: sum of all 16 terms in ACC_W, then saturated:
  - Sum > 0x7FFFFFFF gives 0x7FFFFFFF and sets of.
  - Sum < -2^31 gives 0x80000000 and sets uf.
  - Otherwise the low 32 bits.
- Status flags:
  - of and uf are sticky across the 16 rows.
  - zero = all 16 result lanes equal 0, evaluated on the final vector.
  - inv also sets when start=1 while busy. That start is ignored and the operation in flight is unaffected.
- rst asserted mid-RUN aborts immediately and returns everything to reset values. No done pulse is produced.
- start held high continuously: accepted in every IDLE cycle, so operations chain at 18-cycle spacing. Each ignored busy cycle sets inv for the current operation.

Optional Feature:
- Macro: MVMUL_PIPE_EN.
- Defined:
  - A register stage sits between the 16 term products and the adder tree.
  - RUN lasts 17 cycles. The product is registered in the first cycle; row r is written one cycle after it is selected.
  - done appears in cycle 18. Throughput is 19 cycles per operation.
  - Results are identical to the undefined build.
- Undefined: single-cycle combinational row datapath, as specified above.

Decomposition:
- Already in mtx_types: R, C, V, val3_t, q31_t, mv_t, status_t.
- Add to mtx_types:
  - localparam ACC_W = 37.
  - Typedef acc_t (logic signed [ACC_W-1:0]).
  - Function sat_acc(acc_t) returning q31_t plus of/uf indications.
  - Function mul3_ext(val3_t, q31_t) returning acc_t.
- Add an enum mvmul_state_t {IDLE, RUN, DONE} to the package.
- One natural sub-module: mtx_row_dot.
  - Combinational: 16 mul3_ext terms, a balanced adder tree, and sat_acc.
  - Outputs: q31 result, of, uf, inv.
  - Contains the optional MVMUL_PIPE_EN register.

Test Plan:
1. Identity M (PLUS on the diagonal), v[i] = i*0x01000000 -> done at cycle 17, v_out == v_in, st = 0000.
2. All-MINUS M, v all 0x08000000 -> each lane = -16*2^27 = -2^31 = 0x80000000 exactly, uf=0; busy high cycles 1..17.
3. All-PLUS M, v all 0x7FFFFFFF -> every lane 0x7FFFFFFF, of=1. Repeat with all-MINUS -> lanes 0x80000000, uf=1.
4. Row 0 = MINUS at c=0 only, v[0] = 0x80000000 -> lane0 = 0x7FFFFFFF, of=1 (no wrap). Zero matrix -> all lanes 0, zero=1.
5. start re-pulsed at cycle 5; m_in and v_in changed at cycle 2 -> result uses the latched operands, inv=1, single done at 17. Code 2'b11 in M -> treated as 0, inv=1.
6. rst asserted at cycle 9 -> busy, done, v_out and st go to 0 asynchronously, no done pulse. A fresh start after release completes normally. Repeat tests 1-6 with MVMUL_PIPE_EN defined -> done at cycle 18.
